// File: rtl/song_sequencer.sv
// Song sequencer: walks the note ROM one address per musical step, registers the
// returned note for the tone generator and display, and handles start/pause/stop.
module song_sequencer #(
    parameter int TICKS_PER_STEP = 12_500_000,
    parameter int SONG_LEN       = 241,
    parameter bit LOOP           = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       pause,
    input  logic       stop,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_note,
    output logic [7:0] note,
    output logic       note_valid,
    output logic       step_strobe,
    output logic       playing,
    output logic       done
);

    localparam int            CW        = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(TICKS_PER_STEP - 1);
    localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [7:0]    ADDR_LAST = 8'(SONG_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_PAUSE = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [7:0]    addr_r, addr_s;
    logic [7:0]    note_r, note_s;
    logic          start_d_r;
    logic          start_edge_s;
    logic          note_valid_r, step_strobe_r, playing_r, done_r;

    assign start_edge_s = start & ~start_d_r;

    // Next-state, next-address, next-counter and next-note decode.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        note_s  = note_r;
        if (stop) begin
            state_s = S_IDLE;
            cnt_s   = CNT_ZERO;
            addr_s  = 8'd0;
            note_s  = 8'd0;
        end else if (start_edge_s) begin
            // Restart from the top; note keeps its old value through ADDR/LOAD.
            state_s = S_ADDR;
            cnt_s   = CNT_ZERO;
            addr_s  = 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    state_s = S_IDLE;
                end
                S_ADDR: begin
                    state_s = S_LOAD;
                end
                S_LOAD: begin
                    note_s  = rom_note;
                    cnt_s   = CNT_ZERO;
                    state_s = S_PLAY;
                end
                S_PLAY: begin
                    // A finishing step always completes, even if pause arrives on its last tick.
                    if (cnt_r == CNT_LAST) begin
                        cnt_s = CNT_ZERO;
                        if (addr_r != ADDR_LAST) begin
                            addr_s  = addr_r + 8'd1;
                            state_s = S_ADDR;
                        end else if (LOOP) begin
                            addr_s  = 8'd0;
                            state_s = S_ADDR;
                        end else begin
                            note_s  = 8'd0;
                            state_s = S_DONE;
                        end
                    end else if (pause) begin
                        state_s = S_PAUSE;
                    end else begin
                        cnt_s = cnt_r + CNT_ONE;
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        state_s = S_PLAY;
                    end else begin
                        state_s = S_PAUSE;
                    end
                end
                S_DONE: begin
                    state_s = S_DONE;
                end
                default: begin
                    state_s = S_IDLE;
                    cnt_s   = CNT_ZERO;
                    addr_s  = 8'd0;
                    note_s  = 8'd0;
                end
            endcase
        end
    end

    // State, datapath and output registers; flags are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            cnt_r         <= CNT_ZERO;
            addr_r        <= 8'd0;
            note_r        <= 8'd0;
            start_d_r     <= start;
            note_valid_r  <= 1'b0;
            step_strobe_r <= 1'b0;
            playing_r     <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            addr_r        <= addr_s;
            note_r        <= note_s;
            start_d_r     <= start;
            note_valid_r  <= (state_s == S_PLAY);
            step_strobe_r <= (state_s == S_PLAY) && (cnt_s == CNT_LAST);
            playing_r     <= (state_s == S_ADDR) || (state_s == S_LOAD) || (state_s == S_PLAY);
            done_r        <= (state_s == S_DONE);
        end
    end

    assign rom_addr    = addr_r;
    assign note        = note_r;
    assign note_valid  = note_valid_r;
    assign step_strobe = step_strobe_r;
    assign playing     = playing_r;
    assign done        = done_r;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer: a one-shot and a looping instance, notes
// checked against a scoreboard of (note, cycle) entries pushed at each start.
module tb_song_sequencer;

    localparam int T  = 4;
    localparam int SL = 5;

    typedef struct {
        logic [7:0] note;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, start, pause, stop, start_l, pause_l, stop_l;
    logic [7:0] rom_addr, rom_note, note, rom_addr_l, rom_note_l, note_l;
    logic       note_valid, step_strobe, playing, done;
    logic       note_valid_l, step_strobe_l, playing_l, done_l;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   strobes0 = 0;
    int   strobes1 = 0;
    logic done_seen_l = 1'b0;
    logic nv0_q = 1'b0, pl0_q = 1'b0, nv1_q = 1'b0, pl1_q = 1'b0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    song_sequencer #(.TICKS_PER_STEP(T), .SONG_LEN(SL), .LOOP(1'b0)) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .stop(stop),
        .rom_addr(rom_addr), .rom_note(rom_note), .note(note), .note_valid(note_valid),
        .step_strobe(step_strobe), .playing(playing), .done(done)
    );

    song_sequencer #(.TICKS_PER_STEP(T), .SONG_LEN(SL), .LOOP(1'b1)) dut_l (
        .clk(clk), .reset(reset), .start(start_l), .pause(pause_l), .stop(stop_l),
        .rom_addr(rom_addr_l), .rom_note(rom_note_l), .note(note_l), .note_valid(note_valid_l),
        .step_strobe(step_strobe_l), .playing(playing_l), .done(done_l)
    );

    function automatic logic [7:0] song(input int idx);
        case (idx % SL)
            0:       return 8'd25;
            1:       return 8'd27;
            2:       return 8'd0;
            3:       return 8'd22;
            4:       return 8'd30;
            default: return 8'hEE;
        endcase
    endfunction

    // Behavioural note ROM with one cycle of registered read latency.
    always @(posedge clk) begin
        rom_note   <= song(int'(rom_addr));
        rom_note_l <= song(int'(rom_addr_l));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag, inout exp_t q[$], input logic [7:0] obs_note);
        exp_t e;
        chk({tag, " pending"}, 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
            e = q.pop_front();
            chk({tag, " note"}, 32'(obs_note), 32'(e.note));
            chk({tag, " cycle"}, 32'(cyc), 32'(e.cyc));
        end else begin
            e.cyc = 0;
        end
    endtask

    // One cycle: advance to the sampling edge and run the output monitors.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (step_strobe === 1'b1) strobes0++;
        if (step_strobe_l === 1'b1) strobes1++;
        if (done_l === 1'b1) done_seen_l = 1'b1;
        if (note_valid === 1'b1 && !nv0_q && pl0_q) pop_chk("sb0", q0, note);
        if (note_valid_l === 1'b1 && !nv1_q && pl1_q) pop_chk("sb1", q1, note_l);
        nv0_q = (note_valid === 1'b1);
        pl0_q = (playing === 1'b1);
        nv1_q = (note_valid_l === 1'b1);
        pl1_q = (playing_l === 1'b1);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, " note"}, 32'(note), 32'd0);
        chk({tag, " note_valid"}, 32'(note_valid), 32'd0);
        chk({tag, " step_strobe"}, 32'(step_strobe), 32'd0);
        chk({tag, " playing"}, 32'(playing), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int c0, cn, cm, ck, s0;
        reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        start_l = 1'b0; pause_l = 1'b0; stop_l = 1'b0;
        repeat (3) step();
        rst_chk("reset");
        chk("reset rom_addr_l", 32'(rom_addr_l), 32'd0);
        chk("reset playing_l", 32'(playing_l), 32'd0);
        reset = 1'b0;
        step();

        // Full song on both instances; the looping one is stopped after 8 notes.
        c0 = cyc;
        start = 1'b1; start_l = 1'b1;
        for (int k = 0; k < 5; k++) q0.push_back('{song(k), c0 + 3 + 6 * k});
        for (int k = 0; k < 8; k++) q1.push_back('{song(k), c0 + 3 + 6 * k});
        step();
        start = 1'b0; start_l = 1'b0;
        chk("addr after start", 32'(rom_addr), 32'd0);
        chk("playing in ADDR", 32'(playing), 32'd1);
        chk("note_valid in ADDR", 32'(note_valid), 32'd0);
        run_to(c0 + 31);
        chk("done at end", 32'(done), 32'd1);
        chk("playing at end", 32'(playing), 32'd0);
        chk("note at end", 32'(note), 32'd0);
        chk("note_valid at end", 32'(note_valid), 32'd0);
        chk("addr held at end", 32'(rom_addr), 32'd4);
        chk("strobes per song", 32'(strobes0), 32'd5);
        chk("sb0 drained", 32'(q0.size()), 32'd0);
        chk("loop addr wrap", 32'(rom_addr_l), 32'd0);
        chk("loop still playing", 32'(playing_l), 32'd1);
        run_to(c0 + 46);
        chk("sb1 drained", 32'(q1.size()), 32'd0);
        chk("loop strobes", 32'(strobes1), 32'd7);
        chk("loop never done", 32'(done_seen_l), 32'd0);
        stop_l = 1'b1;
        step();
        stop_l = 1'b0;
        chk("loop stop playing", 32'(playing_l), 32'd0);
        chk("loop stop addr", 32'(rom_addr_l), 32'd0);
        chk("loop stop note", 32'(note_l), 32'd0);

        // Pause at counter 2 of address 1, then stop during LOAD of address 3.
        cn = cyc; s0 = strobes0;
        start = 1'b1;
        q0.push_back('{8'd25, cn + 3});
        q0.push_back('{8'd27, cn + 9});
        q0.push_back('{8'd0, cn + 26});
        step();
        start = 1'b0;
        run_to(cn + 11);
        pause = 1'b1;
        run_to(cn + 12);
        chk("pause note", 32'(note), 32'd27);
        chk("pause note_valid", 32'(note_valid), 32'd0);
        chk("pause playing", 32'(playing), 32'd0);
        run_to(cn + 21);
        chk("pause note held", 32'(note), 32'd27);
        chk("no strobe in pause", 32'(strobes0 - s0), 32'd1);
        pause = 1'b0;
        run_to(cn + 22);
        chk("resume note_valid", 32'(note_valid), 32'd1);
        chk("resume strobe early", 32'(step_strobe), 32'd0);
        run_to(cn + 23);
        chk("resume strobe", 32'(step_strobe), 32'd1);
        run_to(cn + 31);
        chk("load addr 3", 32'(rom_addr), 32'd3);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop playing", 32'(playing), 32'd0);
        chk("stop note", 32'(note), 32'd0);
        chk("stop addr", 32'(rom_addr), 32'd0);
        chk("stop done", 32'(done), 32'd0);
        run_to(cn + 40);
        chk("strobes to stop", 32'(strobes0 - s0), 32'd3);
        chk("idle after stop", 32'(playing), 32'd0);
        chk("sb0 after stop", 32'(q0.size()), 32'd0);

        // Held start does not retrigger; a fresh edge in PLAY restarts at address 0.
        cm = cyc;
        start = 1'b1;
        q0.push_back('{8'd25, cm + 3});
        q0.push_back('{8'd27, cm + 9});
        q0.push_back('{8'd0, cm + 15});
        q0.push_back('{8'd25, cm + 19});
        run_to(cm + 10);
        start = 1'b0;
        run_to(cm + 16);
        chk("rest note_valid", 32'(note_valid), 32'd1);
        chk("rest addr", 32'(rom_addr), 32'd2);
        start = 1'b1;
        step();
        chk("restart addr", 32'(rom_addr), 32'd0);
        chk("restart note held", 32'(note), 32'd0);
        chk("restart note_valid", 32'(note_valid), 32'd0);
        chk("restart playing", 32'(playing), 32'd1);
        run_to(cm + 21);

        // Reset mid-PLAY together with a held start.
        reset = 1'b1;
        step();
        rst_chk("midplay reset");
        reset = 1'b0;
        run_to(cm + 26);
        chk("held start idle", 32'(playing), 32'd0);
        chk("held start addr", 32'(rom_addr), 32'd0);
        start = 1'b0;
        step();
        ck = cyc;
        start = 1'b1;
        q0.push_back('{8'd25, ck + 3});
        step();
        start = 1'b0;
        chk("new edge playing", 32'(playing), 32'd1);
        run_to(ck + 4);
        chk("sb0 final", 32'(q0.size()), 32'd0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("final stop", 32'(playing), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
Name: song_sequencer

Overview:
- Drives the address of the song note ROM and registers the returned note index for the downstream tone generator and falling-note display.
- Advances one ROM address per musical step at a fixed tempo.
- Handles start, pause and stop, and reports end-of-song.
- The ROM has one-cycle registered read latency: address in, note out on the next clk edge.

Parameters:
- TICKS_PER_STEP, 12_500_000: clk cycles spent in PLAY per step (125 ms at 100 MHz).
- SONG_LEN, 241: number of valid ROM entries, addresses 0..SONG_LEN-1; must be 1..256.
- LOOP, 0: 1 = wrap to address 0 after the last step; 0 = stop in DONE.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  level, sampled each cycle; starts or restarts the song from address 0
- pause  in  1  level; while high, playback is frozen
- stop  in  1  level; aborts playback, returns to IDLE
- rom_addr  out  8  registered address to the note ROM
- rom_note  in  8  note index from the ROM, valid 1 cycle after rom_addr changes
- note  out  8  current note index (0 = rest/silence)
- note_valid  out  1  high while a note is sounding (PLAY only)
- step_strobe  out  1  one-cycle pulse at the end of each step
- playing  out  1  high in ADDR, LOAD, PLAY
- done  out  1  high in DONE

Behaviour:
- Reset values: rom_addr=0, note=0, note_valid=0, step_strobe=0, playing=0, done=0, tick counter=0, state=IDLE.
- Reset overrides everything in the same cycle.
- Input priority: stop > start > pause.
- States:
  - IDLE: outputs at reset values. start -> ADDR with rom_addr=0.
  - ADDR: rom_addr stable for 1 cycle while the ROM registers it. Always -> LOAD.
  - LOAD: rom_note valid; note<=rom_note, tick counter<=0. -> PLAY.
  - PLAY: note_valid=1, counter increments each cycle.
    - When counter==TICKS_PER_STEP-1: step_strobe=1 for that cycle.
    - If rom_addr==SONG_LEN-1: LOOP=0 -> DONE; LOOP=1 -> rom_addr<=0, -> ADDR.
    - Otherwise rom_addr<=rom_addr+1, -> ADDR.
    - pause=1 (and no stop/start) -> PAUSE.
  - PAUSE: counter frozen; note held; note_valid=0; playing=0. pause=0 -> PLAY, counter resumes from its held value.
  - DONE: done=1, note=0, note_valid=0, rom_addr holds SONG_LEN-1. start -> ADDR with rom_addr=0.
- stop in any state: -> IDLE next cycle; note=0, rom_addr=0, counter=0, step_strobe not asserted.
- start in PLAY, PAUSE, ADDR or LOAD: restart; rom_addr<=0, counter<=0, -> ADDR.
- start held high does not re-trigger once playing; restart requires a new start while not already in ADDR/LOAD state with rom_addr=0.
- Simplification: start is treated as a restart only on its 0->1 edge. This requires an internal start_d register.
- Timing:
  - start edge to first note: start sampled at edge k; ADDR at k+1; LOAD at k+2; note updates at edge k+3.
  - Step period, note change to note change: TICKS_PER_STEP+2 cycles. During ADDR/LOAD, note holds the previous value; note_valid=0.
- Rests: rom_note=0 mid-song is played as a rest. note=0 and note_valid=1 is legal, and the step is counted normally.
- Widths: counter width = clog2(TICKS_PER_STEP). rom_addr increment never exceeds SONG_LEN-1; no 8-bit overflow even at SONG_LEN=256.
- SONG_LEN=1: every step ends the song (LOOP=0) or replays address 0 (LOOP=1).

Test Plan:
(Use TICKS_PER_STEP=4, SONG_LEN=5, and a behavioural ROM returning {25,27,0,22,30} with 1-cycle latency.)
- Reset, then start pulse at cycle 0 -> rom_addr=0; note=25 at cycle 3. note changes 25,27,0,22,30 every 6 cycles. step_strobe pulses 5 times. Then done=1, note=0, playing=0.
- LOOP=1, same stimulus -> after 30 at addr 4, rom_addr wraps to 0, note=25 again; done never asserts.
- pause high for 10 cycles at counter=2 in step addr 1 -> note holds 27, note_valid=0, no step_strobe during the pause. After release, step_strobe fires exactly 2 cycles later.
- stop asserted during LOAD of addr 3 -> next cycle state IDLE, note=0, rom_addr=0; no further step_strobe.
- start re-pulsed in PLAY at addr 2 -> rom_addr=0 next cycle; note=25 three cycles after the start edge.
- reset asserted mid-PLAY together with start -> all outputs at reset values the next cycle; stays IDLE until a new start edge.
